// File: rtl/cpu_pkg.sv
// Shared constants for the fetch/decode/execute controller: state encoding,
// instruction opcodes and the one-hot register/writeback selects.
package cpu_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned NSEL_W = 3;
  localparam int unsigned VSEL_W = 4;

  typedef enum logic [4:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WB_IMM,
    S_LDA,
    S_LDB_M,
    S_SHIFT,
    S_ALU,
    S_WB_C,
    S_FLAGS,
    S_ADDR,
    S_MEM_RD,
    S_ALAT,
    S_LDB_D,
    S_PASS,
    S_MEM_WR,
    S_HALT
  } state_e;

  // ir[15:11]: {opcode, op}
  localparam logic [OP_W-1:0] OP_MOVI = 5'b110_10;
  localparam logic [OP_W-1:0] OP_MOV  = 5'b110_00;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b101_00;
  localparam logic [OP_W-1:0] OP_CMP  = 5'b101_01;
  localparam logic [OP_W-1:0] OP_AND  = 5'b101_10;
  localparam logic [OP_W-1:0] OP_MVN  = 5'b101_11;
  localparam logic [OP_W-1:0] OP_LDR  = 5'b011_00;
  localparam logic [OP_W-1:0] OP_STR  = 5'b100_00;
  localparam logic [2:0]      OPC_HALT = 3'b111;

  localparam logic [NSEL_W-1:0] NSEL_NONE = 3'b000;
  localparam logic [NSEL_W-1:0] NSEL_RN   = 3'b100;
  localparam logic [NSEL_W-1:0] NSEL_RD   = 3'b010;
  localparam logic [NSEL_W-1:0] NSEL_RM   = 3'b001;

  localparam logic [VSEL_W-1:0] VSEL_NONE  = 4'b0000;
  localparam logic [VSEL_W-1:0] VSEL_MDATA = 4'b1000;
  localparam logic [VSEL_W-1:0] VSEL_IMM   = 4'b0100;
  localparam logic [VSEL_W-1:0] VSEL_PC    = 4'b0010;
  localparam logic [VSEL_W-1:0] VSEL_C     = 4'b0001;

endpackage

// File: rtl/pc_reg.sv
// Program counter: loads the start address or increments, wrapping at 2^ADDR_W.
module pc_reg #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= ADDR_W'(RESET_PC);
    end else if (load) begin
      pc <= ADDR_W'(RESET_PC);
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle fetch/decode/execute controller with IR, PC, memory handshake
// and HALT. Controls are a Moore decode of the state register.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rdy,
  input  logic [15:0]       dp_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        nsel,
  output logic [3:0]        vsel,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic              w,
  output logic              halted,
  output logic              illegal
);

  state_e            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [OP_W-1:0]   op;
  logic              pc_load, pc_inc, ir_load, addr_load, illegal_set;
  logic              dp_unused;

  assign op        = ir[15:11];
  assign dp_unused = ^dp_out;

  pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .inc   (pc_inc),
    .pc    (pc)
  );

  // State, instruction register, STR address latch, sticky illegal flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      ir      <= '0;
      addr_q  <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (ir_load)     ir      <= mem_rdata;
      if (addr_load)   addr_q  <= dp_out[ADDR_W-1:0];
      if (illegal_set) illegal <= 1'b1;
    end
  end

  // Next state and per-state controls
  always_comb begin
    state_nx    = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    nsel        = NSEL_NONE;
    vsel        = VSEL_NONE;
    write       = 1'b0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    w           = 1'b0;
    halted      = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    ir_load     = 1'b0;
    addr_load   = 1'b0;
    illegal_set = 1'b0;
    case (state)
      S_IDLE: begin
        w = 1'b1;
        if (run) begin
          pc_load  = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_rdy) begin
          ir_load  = 1'b1;
          pc_inc   = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OP_MOVI:                                 state_nx = S_WB_IMM;
          OP_MOV, OP_MVN:                          state_nx = S_LDB_M;
          OP_ADD, OP_AND, OP_CMP, OP_LDR, OP_STR:  state_nx = S_LDA;
          default: begin
            state_nx    = S_HALT;
            illegal_set = (op[4:2] != OPC_HALT);
          end
        endcase
      end
      S_WB_IMM: begin
        nsel     = NSEL_RN;
        vsel     = VSEL_IMM;
        write    = 1'b1;
        state_nx = S_FETCH;
      end
      S_LDA: begin
        nsel     = NSEL_RN;
        loada    = 1'b1;
        state_nx = (op == OP_LDR || op == OP_STR) ? S_ADDR : S_LDB_M;
      end
      S_LDB_M: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
        if (op == OP_MOV)      state_nx = S_SHIFT;
        else if (op == OP_CMP) state_nx = S_FLAGS;
        else                   state_nx = S_ALU;
      end
      S_SHIFT: begin
        asel     = 1'b1;
        loadc    = 1'b1;
        state_nx = S_WB_C;
      end
      S_ALU: begin
        loadc    = 1'b1;
        state_nx = S_WB_C;
      end
      S_WB_C: begin
        nsel     = NSEL_RD;
        vsel     = VSEL_C;
        write    = 1'b1;
        state_nx = S_FETCH;
      end
      S_FLAGS: begin
        loads    = 1'b1;
        state_nx = S_FETCH;
      end
      S_ADDR: begin
        bsel     = 1'b1;
        loadc    = 1'b1;
        state_nx = (op == OP_LDR) ? S_MEM_RD : S_ALAT;
      end
      // Writeback select is held for the whole read; the write strobe follows ready
      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = dp_out[ADDR_W-1:0];
        nsel     = NSEL_RD;
        vsel     = VSEL_MDATA;
        write    = mem_rdy;
        if (mem_rdy) state_nx = S_FETCH;
      end
      S_ALAT: begin
        addr_load = 1'b1;
        state_nx  = S_LDB_D;
      end
      S_LDB_D: begin
        nsel     = NSEL_RD;
        loadb    = 1'b1;
        state_nx = S_PASS;
      end
      S_PASS: begin
        asel     = 1'b1;
        loadc    = 1'b1;
        state_nx = S_MEM_WR;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr_q;
        if (mem_rdy) state_nx = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed reset/halt/wrap steps plus randomized
// instruction streams checked against a per-opcode behavioural model.
module tb_cpu_controller;

  localparam int unsigned AW = 9;

  localparam logic [4:0] T_MOVI = 5'b11010;
  localparam logic [4:0] T_MOV  = 5'b11000;
  localparam logic [4:0] T_ADD  = 5'b10100;
  localparam logic [4:0] T_CMP  = 5'b10101;
  localparam logic [4:0] T_AND  = 5'b10110;
  localparam logic [4:0] T_MVN  = 5'b10111;
  localparam logic [4:0] T_LDR  = 5'b01100;
  localparam logic [4:0] T_STR  = 5'b10000;

  logic          clk, reset, run, mem_rdy;
  logic [15:0]   mem_rdata, dp_out;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr, pc;
  logic [15:0]   ir;
  logic [2:0]    nsel;
  logic [3:0]    vsel;
  logic          write, loada, loadb, loadc, loads, asel, bsel, w, halted, illegal;

  logic          run2, rdy2;
  logic [15:0]   rdata2, dp2;
  logic          req2, we2;
  logic [3:0]    addr2, pc2;
  logic [15:0]   ir2;
  logic [2:0]    nsel2;
  logic [3:0]    vsel2;
  logic          write2, la2, lb2, lc2, ls2, as2, bs2, w2, halted2, illegal2;

  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [AW-1:0] model_pc;

  cpu_controller #(.ADDR_W(AW), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .dp_out(dp_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .ir(ir), .pc(pc), .nsel(nsel), .vsel(vsel), .write(write), .loada(loada),
    .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .w(w), .halted(halted), .illegal(illegal)
  );

  cpu_controller #(.ADDR_W(4), .RESET_PC(15)) dut_w (
    .clk(clk), .reset(reset), .run(run2), .mem_rdata(rdata2), .mem_rdy(rdy2),
    .dp_out(dp2), .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
    .ir(ir2), .pc(pc2), .nsel(nsel2), .vsel(vsel2), .write(write2), .loada(la2),
    .loadb(lb2), .loadc(lc2), .loads(ls2), .asel(as2), .bsel(bs2),
    .w(w2), .halted(halted2), .illegal(illegal2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-opcode profile: {cycles, writes, loada, loadb, loadc, loads, asel, bsel}
  function automatic logic [31:0] exp_sig(input logic [4:0] op);
    case (op)
      T_MOVI:        return 32'h3100_0000;
      T_MOV:         return 32'h5101_1010;
      T_ADD, T_AND:  return 32'h6111_1000;
      T_CMP:         return 32'h5011_0100;
      T_MVN:         return 32'h5101_1000;
      T_LDR:         return 32'h5110_1001;
      T_STR:         return 32'h8011_2011;
      default:       return 32'h0;
    endcase
  endfunction

  function automatic logic [4:0] pick_op(input int i);
    case (i)
      0: return T_MOVI;  1: return T_MOV;  2: return T_ADD;  3: return T_AND;
      4: return T_CMP;   5: return T_MVN;  6: return T_LDR;  default: return T_STR;
    endcase
  endfunction

  // Runs one instruction starting at its FETCH cycle; wf fetch waits, wm data waits
  task automatic exec_instr(input logic [15:0] instr, input int wf, input int wm,
                            input bit fix_dp, input logic [15:0] dp_fix);
    logic [4:0]    op;
    logic [31:0]   es;
    logic [6:0]    wsig, ewsig;
    logic [AW-1:0] str_addr;
    int            acc_k, total, k, bad;
    int            nwr, na, nb, nc, ns, nas, nbs;
    op       = instr[15:11];
    es       = exp_sig(op);
    acc_k    = (op == T_LDR) ? 4 : (op == T_STR) ? 7 : -1;
    total    = wf + int'(es[31:28]) + ((acc_k >= 0) ? wm : 0);
    ewsig    = (op == T_MOVI) ? 7'b100_0100 : (op == T_LDR) ? 7'b010_1000 :
               (es[27:24] != 4'd0) ? 7'b010_0001 : 7'b000_0000;
    wsig     = '0;
    str_addr = '0;
    bad = 0; nwr = 0; na = 0; nb = 0; nc = 0; ns = 0; nas = 0; nbs = 0;
    for (int c = 0; c < total; c++) begin
      k = c - wf;
      @(negedge clk);
      run       = 1'($urandom);
      dp_out    = fix_dp ? dp_fix : 16'($urandom);
      mem_rdata = (k == 0) ? instr : 16'($urandom);
      if (k < 0)                         mem_rdy = 1'b0;
      else if (k == 0)                   mem_rdy = 1'b1;
      else if (acc_k >= 0 && k >= acc_k) mem_rdy = (k == acc_k + wm);
      else                               mem_rdy = 1'($urandom);
      #1;
      if (c == 0) begin
        check("fetch_addr", 32'(mem_addr), 32'(model_pc));
        check("fetch_req", 32'({mem_req, mem_we}), 32'(2'b10));
      end
      if (k <= 0) begin
        if (!mem_req || mem_we || mem_addr !== model_pc) bad++;
      end else if (acc_k >= 0 && k >= acc_k) begin
        if (op == T_LDR) begin
          if (!mem_req || mem_we || mem_addr !== dp_out[AW-1:0] || nsel !== 3'b010 ||
              vsel !== 4'b1000 || write !== mem_rdy) bad++;
        end else begin
          if (!mem_req || !mem_we || mem_addr !== str_addr) bad++;
        end
      end else if (mem_req || mem_we) begin
        bad++;
      end
      if (k == 1) begin
        check("ir", 32'(ir), 32'(instr));
        check("pc_inc", 32'(pc), 32'(AW'(model_pc + 1)));
      end
      if (k == 4) str_addr = dp_out[AW-1:0];
      if (w || halted || illegal) bad++;
      if (write) begin nwr++; wsig = {nsel, vsel}; end
      if (loada) begin na++; if (nsel !== 3'b100) bad++; end
      if (loadb) begin nb++; if (nsel !== ((op == T_STR) ? 3'b010 : 3'b001)) bad++; end
      if (loadc) nc++;
      if (loads) ns++;
      if (asel)  nas++;
      if (bsel)  nbs++;
    end
    check("ctl_counts", 32'({4'(nwr), 4'(na), 4'(nb), 4'(nc), 4'(ns), 4'(nas), 4'(nbs)}),
          32'(es[27:0]));
    check("wb_select", 32'(wsig), 32'(ewsig));
    check("cycle_bad", 32'(bad), 32'd0);
    model_pc = AW'(model_pc + 1);
  endtask

  initial begin
    int bad;
    logic [15:0] instr;
    reset = 1'b1; run = 1'b0; mem_rdy = 1'b0; mem_rdata = '0; dp_out = '0;
    run2 = 1'b0; rdy2 = 1'b0; rdata2 = '0; dp2 = '0;
    model_pc = '0;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_w", 32'(w), 32'd1);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_ctl", 32'({mem_req, mem_we, mem_addr, nsel, vsel, write, loada, loadb, loadc,
                          loads, asel, bsel, halted, illegal}), 32'd0);

    // run to first request, then asynchronous reset in the middle of FETCH
    @(negedge clk); reset = 1'b1;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0; mem_rdy = 1'b0; #1;
    check("run_req", 32'(mem_req), 32'd1);
    check("run_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #2; reset = 1'b0; #1;
    check("arst_req", 32'(mem_req), 32'd0);
    check("arst_w", 32'(w), 32'd1);
    check("arst_pc", 32'(pc), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); run = 1'b1;

    // directed: MOVI with fetch waits, ADD, LDR with dp_out=5, STR with 4 stalls
    exec_instr(16'hD207, 3, 0, 1'b0, 16'h0);
    exec_instr(16'hA161, 0, 0, 1'b0, 16'h0);
    exec_instr(16'h6120, 0, 2, 1'b1, 16'h0005);
    exec_instr(16'h8160, 1, 4, 1'b0, 16'h0);

    for (int i = 0; i < 40; i++) begin
      instr = {pick_op(int'($urandom_range(0, 7))), 11'($urandom)};
      exec_instr(instr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 16'h0);
    end
    @(negedge clk); mem_rdy = 1'b0; #1;
    check("final_fetch", 32'({mem_req, mem_we, mem_addr}), 32'({2'b10, model_pc}));

    // HALT: absorbing, run ignored
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1; run = 1'b1;
    @(negedge clk); run = 1'b0; mem_rdy = 1'b1; mem_rdata = 16'hE000;
    @(negedge clk); mem_rdy = 1'b0;
    @(negedge clk); #1;
    check("halt", 32'({halted, illegal}), 32'(2'b10));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); run = 1'b1; mem_rdy = 1'($urandom); #1;
      if (!halted || mem_req || w || illegal) bad++;
    end
    run = 1'b0;
    check("halt_hold", 32'(bad), 32'd0);
    check("halt_pc", 32'(pc), 32'd1);

    // unsupported opcode halts with illegal set
    @(negedge clk); reset = 1'b0; #1;
    check("halt_rst", 32'({halted, w}), 32'(2'b01));
    @(negedge clk); reset = 1'b1; run = 1'b1;
    @(negedge clk); run = 1'b0; mem_rdy = 1'b1; mem_rdata = 16'h0000;
    @(negedge clk); mem_rdy = 1'b0;
    @(negedge clk); #1;
    check("illegal", 32'({halted, illegal}), 32'(2'b11));
    @(negedge clk); reset = 1'b0; #1;
    check("illegal_clr", 32'(illegal), 32'd0);
    @(negedge clk); reset = 1'b1;

    // PC wrap on the 4-bit instance starting at 15
    @(negedge clk); run2 = 1'b1;
    @(negedge clk); run2 = 1'b0; rdy2 = 1'b1; rdata2 = 16'hD207; #1;
    check("wrap_fetch", 32'({req2, addr2}), 32'({1'b1, 4'hF}));
    @(negedge clk); rdy2 = 1'b0; #1;
    check("wrap_pc", 32'(pc2), 32'd0);
    @(negedge clk); #1;
    check("wrap_wb", 32'({nsel2, vsel2, write2}), 32'({3'b100, 4'b0100, 1'b1}));
    @(negedge clk); #1;
    check("wrap_next", 32'({req2, we2, addr2}), 32'({2'b10, 4'h0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multi-cycle fetch/decode/execute controller for the 16-bit datapath. It adds the following on top of the current WAIT/DECODE controller:
- an instruction register
- a program counter of parametrised width
- a request/ready memory handshake for instruction fetch, LDR and STR
- a HALT state

It sits between the external memory and the existing instruction decoder/datapath. Its outputs drive `nsel`, `vsel`, the datapath load enables and the memory port.

## Interface
- `ADDR_W`, 9, width of the PC and memory address.
- `RESET_PC`, 0, PC value loaded on reset and on `run` in IDLE.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  start execution; sampled only in IDLE.
- `mem_rdata`  in  16  memory read data; an instruction in FETCH, `mdata` in MEM_RD.
- `mem_rdy`  in  1  memory completes the current request this cycle.
- `dp_out`  in  16  datapath C register output.
- `mem_req`  out  1  memory request valid.
- `mem_we`  out  1  write request (STR).
- `mem_addr`  out  `ADDR_W`  request address.
- `ir`  out  16  instruction register, feeds the instruction decoder.
- `pc`  out  `ADDR_W`  program counter.
- `nsel`  out  3  one-hot register select: 100 = Rn, 010 = Rd, 001 = Rm.
- `vsel`  out  4  one-hot writeback select: [3] mdata, [2] sximm8, [1] pc, [0] C.
- `write`, `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel`  out  1 each  datapath controls.
- `w`  out  1  high in IDLE only.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  sticky; set when an unsupported opcode halts the core.

## Operation
- Moore machine: all outputs decode from the state register. An output not listed for a state is 0.
- States and transitions:
  - IDLE (`w`=1): on `run`, `pc`<=`RESET_PC` and go to FETCH.
  - FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`. Holds until `mem_rdy`. On `mem_rdy`: `ir`<=`mem_rdata`, `pc`<=`pc`+1 modulo 2^`ADDR_W`, go to DECODE.
  - DECODE: branches on `ir[15:11]`:
    - 110_10 MOVI: WB_IMM (`nsel`=Rn, `vsel`[2], `write`).
    - 110_00 MOV: LDB_M → SHIFT (`asel`, `loadc`) → WB_C.
    - 101_00 ADD and 101_10 AND: LDA → LDB_M → ALU (`loadc`) → WB_C.
    - 101_01 CMP: LDA → LDB_M → FLAGS (`loads` only).
    - 101_11 MVN: LDB_M → ALU → WB_C.
    - 011_00 LDR: LDA → ADDR (`bsel`, `loadc`) → MEM_RD.
    - 100_00 STR: LDA → ADDR → ALAT → LDB_D → PASS (`asel`, `loadc`) → MEM_WR.
    - 111_xx: HALT.
    - Anything else: HALT with `illegal` set.
  - Sub-state controls:
    - LDA: `nsel`=Rn, `loada`.
    - LDB_M: `nsel`=Rm, `loadb`.
    - LDB_D: `nsel`=Rd, `loadb`.
    - WB_C: `nsel`=Rd, `vsel`[0], `write`.
  - All execute paths end by returning to FETCH.
  - MEM_RD: `mem_req`=1, `mem_addr`=`dp_out[ADDR_W-1:0]`. `nsel`=Rd and `vsel`[3] are held throughout; `write`=`mem_rdy`. Holds until `mem_rdy`.
  - ALAT: captures `dp_out[ADDR_W-1:0]` into an internal address register.
  - MEM_WR: `mem_req`=1, `mem_we`=1, `mem_addr`=address register. Holds until `mem_rdy`.
  - HALT: absorbing. Only `reset` leaves it; `run` is ignored.
- `mem_rdy` outside FETCH, MEM_RD and MEM_WR is ignored.
- While `mem_req`=1, `mem_addr` and `mem_we` stay stable.

## Timing
- Reset (asynchronous, on falling `reset`):
  - State goes to IDLE.
  - `pc`=`RESET_PC`, `ir`=0, address register=0, `illegal`=0.
  - All outputs 0 except `w`=1.
- Reset mid-operation aborts any memory request in the same cycle: `mem_req` drops combinationally with the state.
- Minimum cycles per instruction, counted from FETCH entry to the next FETCH entry, with `mem_rdy` high on first request:
  - MOVI 3, MOV 5, ADD/AND 6, CMP 5, MVN 5, LDR 5, STR 8.
- Each wait cycle with `mem_rdy`=0 adds one cycle.
- `run` to first `mem_req`: 1 cycle.
- The PC wraps from 2^`ADDR_W`-1 to 0 with no flag.

## Structure
- Shared package `cpu_pkg` holds:
  - the state encoding constants;
  - the opcode/op constants (110_10, 101_xx, 011_00, 100_00, 111);
  - the `nsel` and `vsel` one-hot constants.
- One natural sub-module: `pc_reg`, a loadable, incrementing, wrap-around counter parametrised by `ADDR_W`.
- The instruction decoder and datapath remain external.

## Test plan
- Reset and run:
  - Assert `reset`=0 mid-FETCH → `mem_req`=0 immediately, `w`=1, `pc`=0.
  - Release reset, pulse `run` → `mem_req`=1 with `mem_addr`=0 on the next cycle.
- MOVI with memory wait:
  - Memory returns 16'hD207 (MOV R2,#7) after 3 wait cycles.
  - Require `ir`=D207 and `pc`=1.
  - Require WB_IMM with `nsel`=100, `vsel`=0100, `write`=1.
  - Require FETCH again at `mem_addr`=1.
- ADD sequence:
  - Fetch 16'hA161 (ADD R3,R1,R1).
  - Require the control trace LDA(`nsel`=100), LDB_M(001), ALU(`loadc`), WB_C(`nsel`=010, `vsel`=0001, `write`), and exactly 6 cycles with no waits.
- LDR then STR:
  - LDR: with `dp_out`=16'h0005 in MEM_RD, require `mem_addr`=5, `mem_we`=0, and `write`=1 only on the `mem_rdy` cycle.
  - STR: require `mem_addr` to equal the ALAT-captured value, `mem_we`=1, and `mem_addr` held for 4 stalled cycles.
- HALT and illegal:
  - 16'hE000 → `halted`=1 with `run` ignored for 20 cycles.
  - A separate run with 16'h0000 → `halted`=1 and `illegal`=1.
- PC wrap:
  - With `ADDR_W`=4 and `RESET_PC`=15, execute one MOVI → next fetch `mem_addr`=0.
